// File: rtl/uart_dump_pkg.sv
// Shared types and constants for the UART memory dump block.
// The CKSUM state is present only when UART_DUMP_CHECKSUM_EN is defined.
package uart_dump_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_DATA_BUS = 32;
    localparam int LEN_W         = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        SEND,
`ifdef UART_DUMP_CHECKSUM_EN
        CKSUM,
`endif
        DONE
    } state_t;

    // Word addresses wrap naturally at the top of the 32-bit space.
    function automatic logic [INST_ADDR_BUS-1:0] next_word_addr(input logic [INST_ADDR_BUS-1:0] a);
        return a + INST_ADDR_BUS'(4);
    endfunction

endpackage

// File: rtl/uart_dump_tx_byte.sv
// 8N1 serializer: one frame per accepted i_start, each bit DIV clocks long.
// o_busy drops in the last stop-bit cycle so a new byte can follow with no idle gap.
module uart_tx_byte #(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_tx
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;
    logic [8:0]       r_shift;
    logic             r_active;
    logic             r_tx;
    logic             w_bit_end;
    logic             w_last;
    logic             w_load;

    assign w_bit_end = (r_cnt == CNT_W'(DIV - 1));
    assign w_last    = r_active && w_bit_end && (r_bit == 4'd9);
    assign o_busy    = r_active && !w_last;
    assign w_load    = i_start && !o_busy;
    assign o_tx      = r_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_tx     <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= '0;
        end else if (w_load) begin
            r_active <= 1'b1;
            r_tx     <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (r_bit == 4'd9) begin
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                end else begin
                    r_bit <= r_bit + 4'd1;
                    r_tx  <= r_shift[0];
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Data bits followed by the stop bit, shifted out LSB first.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_shift <= {1'b1, i_data};
        end else if (r_active && w_bit_end && (r_bit != 4'd9)) begin
            r_shift <= {1'b1, r_shift[8:1]};
        end
    end

endmodule

// File: rtl/uart_dump.sv
// Reads len 32-bit words over RIB from a start address and streams them LSB-first over UART.
// Define UART_DUMP_CHECKSUM_EN to append a modulo-256 byte checksum frame.
module uart_dump
    import uart_dump_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dump_start_i,
    input  logic [INST_ADDR_BUS-1:0] dump_addr_i,
    input  logic [LEN_W-1:0]         dump_len_i,
    output logic                     rib_rd_req_o,
    output logic [INST_ADDR_BUS-1:0] mem_rd_addr_o,
    input  logic                     rib_gnt_i,
    input  logic [INST_DATA_BUS-1:0] mem_rd_data_i,
    output logic                     uart_tx,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int DIV = CLK_FREQ / BAUD;

    state_t           r_state;
    logic [LEN_W-1:0] r_remain;
    logic [1:0]       r_byte_idx;
    logic [23:0]      r_word;
    logic             w_tx_start;
    logic             w_tx_busy;
    logic [7:0]       w_tx_data;
    logic             w_grant;
    logic             w_send_next;
    logic             w_word_end;

    assign w_grant     = (r_state == RD_REQ) && rib_gnt_i;
    assign w_send_next = (r_state == SEND) && !w_tx_busy && (r_byte_idx != 2'd3);
    assign w_word_end  = (r_state == SEND) && !w_tx_busy && (r_byte_idx == 2'd3);

`ifdef UART_DUMP_CHECKSUM_EN
    logic [7:0] r_cksum;
    logic       r_ck_sent;
    logic       w_ck_start;
    logic       w_ck_end;

    assign w_ck_start = (r_state == CKSUM) && !w_tx_busy && !r_ck_sent;
    assign w_ck_end   = (r_state == CKSUM) && !w_tx_busy && r_ck_sent;
`endif

    // Byte 0 goes straight from the bus in the grant cycle; later bytes come from the shifted word.
    always_comb begin
        w_tx_start = w_grant || w_send_next;
        w_tx_data  = mem_rd_data_i[7:0];
        if (r_state == SEND) begin
            w_tx_data = r_word[7:0];
        end
`ifdef UART_DUMP_CHECKSUM_EN
        if (w_ck_start) begin
            w_tx_start = 1'b1;
            w_tx_data  = r_cksum;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            rib_rd_req_o  <= 1'b0;
            mem_rd_addr_o <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            r_remain      <= '0;
            r_byte_idx    <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
            r_cksum       <= '0;
            r_ck_sent     <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (dump_start_i) begin
                        busy_o        <= 1'b1;
                        mem_rd_addr_o <= dump_addr_i & ~INST_ADDR_BUS'(3);
                        r_remain      <= dump_len_i;
`ifdef UART_DUMP_CHECKSUM_EN
                        r_cksum       <= '0;
                        r_ck_sent     <= 1'b0;
`endif
                        if (dump_len_i != '0) begin
                            r_state      <= RD_REQ;
                            rib_rd_req_o <= 1'b1;
                        end else begin
`ifdef UART_DUMP_CHECKSUM_EN
                            r_state <= CKSUM;
`else
                            r_state <= DONE;
                            done_o  <= 1'b1;
`endif
                        end
                    end
                end
                RD_REQ: begin
                    if (rib_gnt_i) begin
                        rib_rd_req_o <= 1'b0;
                        r_byte_idx   <= '0;
                        r_state      <= SEND;
                    end
                end
                SEND: begin
                    if (w_send_next) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end else if (w_word_end) begin
                        r_remain      <= r_remain - LEN_W'(1);
                        mem_rd_addr_o <= next_word_addr(mem_rd_addr_o);
                        if (r_remain != LEN_W'(1)) begin
                            r_state      <= RD_REQ;
                            rib_rd_req_o <= 1'b1;
                        end else begin
`ifdef UART_DUMP_CHECKSUM_EN
                            r_state <= CKSUM;
`else
                            r_state <= DONE;
                            done_o  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef UART_DUMP_CHECKSUM_EN
                CKSUM: begin
                    if (w_ck_start) begin
                        r_ck_sent <= 1'b1;
                    end else if (w_ck_end) begin
                        r_state <= DONE;
                        done_o  <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    busy_o  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
`ifdef UART_DUMP_CHECKSUM_EN
            if (w_tx_start && !w_ck_start) begin
                r_cksum <= r_cksum + w_tx_data;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_word <= mem_rd_data_i[31:8];
        end else if (w_send_next) begin
            r_word <= {8'h00, r_word[23:8]};
        end
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_tx_start),
        .i_data (w_tx_data),
        .o_busy (w_tx_busy),
        .o_tx   (uart_tx)
    );

endmodule

// File: tb/tb_uart_dump.sv
// Directed bench for uart_dump: RIB responder, UART frame decoder and scoreboard.
// Runs with a short bit period (DIV=13) to keep the dump tests compact.
module tb_uart_dump;
    localparam int DIV   = 13;
    localparam int FRAME = 10 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dump_start_i = 1'b0;
    logic [31:0] dump_addr_i = '0;
    logic [15:0] dump_len_i = '0;
    logic        rib_gnt_i = 1'b0;
    logic [31:0] mem_rd_data_i = '0;
    logic        rib_rd_req_o;
    logic [31:0] mem_rd_addr_o;
    logic        uart_tx;
    logic        busy_o;
    logic        done_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int g_cyc = 0;
    int gnt_delay = 0;
    int n_req = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] data_q[$];
    logic [31:0] addr_q[$];
    int          fs_q[$];

    uart_dump #(
        .CLK_FREQ(1300000),
        .BAUD    (100000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dump_start_i (dump_start_i),
        .dump_addr_i  (dump_addr_i),
        .dump_len_i   (dump_len_i),
        .rib_rd_req_o (rib_rd_req_o),
        .mem_rd_addr_o(mem_rd_addr_o),
        .rib_gnt_i    (rib_gnt_i),
        .mem_rd_data_i(mem_rd_data_i),
        .uart_tx      (uart_tx),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // UART receiver: every bit must hold for exactly DIV cycles.
    initial begin : mon
        logic [9:0] bits;
        bit ok;
        bit aborted;
        int st;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                bits = '0;
                ok = 1'b1;
                aborted = 1'b0;
                st = cyc;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % DIV == 0) bits[k / DIV] = uart_tx;
                    else if (uart_tx !== bits[k / DIV]) ok = 1'b0;
                end
                if (!aborted) begin
                    fs_q.push_back(st);
                    chk("frame_timing", 32'(ok), 32'd1);
                    chk("stop_bit", 32'(bits[9]), 32'd1);
                    rx_q.push_back(bits[8:1]);
                end
            end
        end
    end

    // RIB memory model: grants after gnt_delay wait cycles.
    initial begin : resp
        logic [31:0] a0;
        forever begin
            @(negedge clk);
            if (!rst && rib_rd_req_o === 1'b1) begin
                a0 = mem_rd_addr_o;
                addr_q.push_back(a0);
                n_req++;
                for (int d = 0; d < gnt_delay; d++) begin
                    chk("tx_idle_wait", 32'(uart_tx), 32'd1);
                    @(negedge clk);
                    chk("req_held", 32'(rib_rd_req_o), 32'd1);
                    chk("addr_held", mem_rd_addr_o, a0);
                end
                rib_gnt_i = 1'b1;
                if (data_q.size() > 0) mem_rd_data_i = data_q.pop_front();
                else mem_rd_data_i = 32'hDEADBEEF;
                g_cyc = cyc;
                @(negedge clk);
                rib_gnt_i = 1'b0;
                mem_rd_data_i = '0;
                chk("req_drop", 32'(rib_rd_req_o), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #(40000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic clear_q();
        rx_q.delete();
        exp_q.delete();
        data_q.delete();
        addr_q.delete();
        fs_q.delete();
    endtask

    task automatic add_word(input logic [31:0] w);
        data_q.push_back(w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic add_cksum();
`ifdef UART_DUMP_CHECKSUM_EN
        logic [7:0] s;
        s = '0;
        foreach (exp_q[i]) s = s + exp_q[i];
        exp_q.push_back(s);
`endif
    endtask

    task automatic start_dump(input logic [31:0] a, input logic [15:0] len, input logic exp_req);
        @(negedge clk);
        dump_start_i = 1'b1;
        dump_addr_i = a;
        dump_len_i = len;
        @(negedge clk);
        dump_start_i = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
        chk("req_at_n1", 32'(rib_rd_req_o), 32'(exp_req));
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while (done_o !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        if (done_o === 1'b1) begin
            chk({tag, "_busy_in_done"}, 32'(busy_o), 32'd1);
            @(negedge clk);
            chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
            chk({tag, "_busy_clr"}, 32'(busy_o), 32'd0);
        end
    endtask

    task automatic cmp_rx(input string tag);
        chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin : main
        int n0;
        int low;
        int dn;
        int k;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_req", 32'(rib_rd_req_o), 32'd0);
        chk("rst_addr", mem_rd_addr_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        rst = 1'b0;

        // single word, immediate grant
        clear_q();
        gnt_delay = 0;
        data_q.push_back(32'h44332211);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
`ifdef UART_DUMP_CHECKSUM_EN
        exp_q.push_back(8'hAA);
`endif
        start_dump(32'h10000000, 16'd1, 1'b1);
        wait_done(6 * FRAME, "t1");
        cmp_rx("t1");
        chk("t1_nreq", 32'(addr_q.size()), 32'd1);
        if (addr_q.size() > 0) chk("t1_addr", addr_q[0], 32'h10000000);
        chk("t1_nframes_min", 32'(fs_q.size() >= 4), 32'd1);
        if (fs_q.size() >= 4) begin
            chk("t1_start_lat", 32'(fs_q[0] - g_cyc), 32'd1);
            chk("t1_no_gap", 32'(fs_q[3] - fs_q[0]), 32'(3 * FRAME));
        end

        // three words, delayed grant, low address bits ignored
        clear_q();
        gnt_delay = 5;
        add_word(32'hA3A2A1A0);
        add_word(32'hB3B2B1B0);
        add_word(32'hC3C2C1C0);
        add_cksum();
        start_dump(32'h20000003, 16'd3, 1'b1);
        wait_done(16 * FRAME, "t2");
        cmp_rx("t2");
        chk("t2_nreq", 32'(addr_q.size()), 32'd3);
        if (addr_q.size() >= 3) begin
            chk("t2_addr0", addr_q[0], 32'h20000000);
            chk("t2_addr1", addr_q[1], 32'h20000004);
            chk("t2_addr2", addr_q[2], 32'h20000008);
        end

        // zero length
        clear_q();
        n0 = n_req;
`ifdef UART_DUMP_CHECKSUM_EN
        exp_q.push_back(8'h00);
        start_dump(32'h40000000, 16'd0, 1'b0);
        wait_done(2 * FRAME, "t3");
`else
        start_dump(32'h40000000, 16'd0, 1'b0);
        wait_done(1, "t3");
`endif
        chk("t3_no_req", 32'(n_req - n0), 32'd0);
        cmp_rx("t3");

        // address wrap
        clear_q();
        gnt_delay = 1;
        add_word(32'h0BADF00D);
        add_word(32'hCAFEBABE);
        add_cksum();
        start_dump(32'hFFFFFFFC, 16'd2, 1'b1);
        wait_done(11 * FRAME, "t4");
        cmp_rx("t4");
        chk("t4_nreq", 32'(addr_q.size()), 32'd2);
        if (addr_q.size() >= 2) begin
            chk("t4_addr0", addr_q[0], 32'hFFFFFFFC);
            chk("t4_addr1", addr_q[1], 32'h00000000);
        end

        // checksum carry wrap: 0xFF + 0x02 = 0x01
        clear_q();
        gnt_delay = 0;
        add_word(32'h000000FF);
        add_word(32'h00000002);
`ifdef UART_DUMP_CHECKSUM_EN
        exp_q.push_back(8'h01);
`endif
        start_dump(32'h50000000, 16'd2, 1'b1);
        wait_done(11 * FRAME, "t5");
        cmp_rx("t5");

        // reset during second byte, start while busy ignored
        clear_q();
        n0 = n_req;
        gnt_delay = 0;
        add_word(32'h55AA55AA);
        add_word(32'h12345678);
        start_dump(32'h30000000, 16'd2, 1'b1);
        k = 0;
        while (rx_q.size() < 1 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        chk("t6_first_byte", 32'(rx_q.size()), 32'd1);
        repeat (2 * DIV) @(negedge clk);
        dump_start_i = 1'b1;
        dump_addr_i = 32'h77777770;
        dump_len_i = 16'd5;
        @(negedge clk);
        dump_start_i = 1'b0;
        chk("t6_ignore_addr", mem_rd_addr_o, 32'h30000000);
        chk("t6_ignore_req", 32'(rib_rd_req_o), 32'd0);
        chk("t6_ignore_busy", 32'(busy_o), 32'd1);
        repeat (DIV) @(negedge clk);
        chk("t6_mid_frame", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_tx", 32'(uart_tx), 32'd1);
        chk("t6_rst_req", 32'(rib_rd_req_o), 32'd0);
        chk("t6_rst_addr", mem_rd_addr_o, 32'd0);
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        chk("t6_rst_done", 32'(done_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        low = 0;
        dn = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) low++;
            if (done_o === 1'b1) dn++;
        end
        chk("t6_tx_quiet", 32'(low), 32'd0);
        chk("t6_no_done", 32'(dn), 32'd0);
        chk("t6_nreq", 32'(n_req - n0), 32'd1);
        chk("t6_nbytes", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("t6_byte0", 32'(rx_q[0]), 32'h000000AA);
        chk("t6_idle_busy", 32'(busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_dump.md
UART_DUMP -- requirements
Module: uart_dump

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate; bit period DIV = CLK_FREQ/BAUD (integer division, 434 at defaults).
REQ-003 SHALL have port clk  input  1  system clock, single clock domain.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port dump_start_i  input  1  one-cycle request to start a dump.
REQ-006 SHALL have port dump_addr_i  input  32  start byte address; bits [1:0] ignored, treated as 0.
REQ-007 SHALL have port dump_len_i  input  16  number of 32-bit words to send.
REQ-008 SHALL have port rib_rd_req_o  input-side master request  output  1  RIB read request.
REQ-009 SHALL have port mem_rd_addr_o  output  32  RIB read address.
REQ-010 SHALL have port rib_gnt_i  input  1  RIB grant; mem_rd_data_i valid in the same cycle.
REQ-011 SHALL have port mem_rd_data_i  input  32  RIB read data.
REQ-012 SHALL have port uart_tx  output  1  serial output, 8N1, idle high.
REQ-013 SHALL have ports busy_o (output, 1, dump in progress) and done_o (output, 1, one-cycle pulse at dump end).

Function
REQ-014 SHALL use states IDLE, RD_REQ, SEND, CKSUM, DONE; CKSUM exists only when UART_DUMP_CHECKSUM_EN is defined.
REQ-015 SHALL accept dump_start_i only in IDLE; start while busy_o=1 is ignored.
REQ-016 SHALL, on start accepted in cycle N with dump_len_i>0, latch address and length and assert rib_rd_req_o in cycle N+1 (IDLE->RD_REQ).
REQ-017 SHALL hold rib_rd_req_o and mem_rd_addr_o stable until rib_gnt_i=1, latch mem_rd_data_i in that grant cycle, deassert rib_rd_req_o the next cycle, then enter SEND.
REQ-018 SHALL send the latched word as 4 bytes, least-significant byte first, each frame = start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly DIV cycles.
REQ-019 SHALL drive the first start bit in the cycle after the data latch and send consecutive bytes with no idle gap (frame = 10*DIV cycles).
REQ-020 SHALL, after the 4th stop bit, decrement remaining count, add 4 to address (32-bit wrap-around, 0xFFFFFFFC -> 0x00000000), and return to RD_REQ if count>0, else go to CKSUM or DONE.
REQ-021 SHALL pulse done_o for exactly one cycle in DONE, then return to IDLE with busy_o=0 the following cycle.
REQ-022 SHALL, for dump_len_i=0, issue no RIB request, send no data bytes, and go directly to CKSUM (if enabled) or DONE.
REQ-023 SHALL assert busy_o from the cycle after start acceptance until the cycle after done_o.
REQ-024 SHALL keep uart_tx=1 in IDLE, RD_REQ and DONE, including while waiting on grant between words.

Reset
REQ-025 SHALL, on rst=1, immediately force state IDLE, uart_tx=1, rib_rd_req_o=0, mem_rd_addr_o=0, busy_o=0, done_o=0, checksum=0.
REQ-026 SHALL abort any in-progress frame or RIB request on reset with no further bytes emitted after release.

Configuration
REQ-027 SHALL, with UART_DUMP_CHECKSUM_EN defined, accumulate an 8-bit modulo-256 sum of all sent data bytes and send it as one extra frame in CKSUM before DONE.
REQ-028 SHALL, without UART_DUMP_CHECKSUM_EN, contain no checksum logic and go SEND->DONE directly.

Structure
REQ-029 SHALL take bus widths (INST_ADDR_BUS, INST_DATA_BUS) from the shared defines.v; state encodings stay local.
REQ-030 SHALL instantiate one sub-module uart_tx_byte (byte in, start strobe, busy, serial out, DIV parameter) for frame serialization.

Verification
REQ-031 SHALL test: start addr=0x10000000, len=1, gnt same cycle, data=0x44332211 -> rd_req at N+1, bytes 0x11,0x22,0x33,0x44 on uart_tx, each bit 434 cycles, done_o one pulse.
REQ-032 SHALL test: len=3, gnt delayed 5 cycles per word -> addresses 0x...00/04/08, rd_req held stable during wait, uart_tx high during waits.
REQ-033 SHALL test: len=0 -> no rib_rd_req_o, done_o within 2 cycles (checksum off) or one 0x00 frame then done_o (checksum on).
REQ-034 SHALL test: addr=0xFFFFFFFC, len=2 -> second read at 0x00000000.
REQ-035 SHALL test: checksum on, data 0x000000FF then 0x00000002 -> checksum frame 0x01.
REQ-036 SHALL test: rst=1 mid-frame of byte 2, and dump_start_i while busy -> uart_tx=1 immediately, outputs at reset values, no further frames; start while busy ignored.
